// File: rtl/m14k_ejt_tapfsm.sv
// EJTAG TAP controller: IEEE 1149.1 TAP state machine plus
// the EJTAG instruction register and its shift path.
module m14k_ejt_tapfsm #(
  parameter int unsigned IR_WIDTH = 5,
  parameter logic [IR_WIDTH-1:0] IR_RESET = 5'h01,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 5'h01
) (
  input  logic                EJ_TCK,
  input  logic                treset,
  input  logic                EJ_TMS,
  input  logic                EJ_TDI,
  output logic [3:0]          tap_state,
  output logic                test_logic_reset,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                capture_ir,
  output logic                shift_ir,
  output logic                update_ir,
  output logic [IR_WIDTH-1:0] ir_inst,
  output logic                ir_tdo,
  output logic                tdo_en
);

  localparam logic [3:0] S_TLR   = 4'hF;
  localparam logic [3:0] S_RTI   = 4'hC;
  localparam logic [3:0] S_SELDR = 4'h7;
  localparam logic [3:0] S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHDR  = 4'h2;
  localparam logic [3:0] S_EX1DR = 4'h1;
  localparam logic [3:0] S_PSDR  = 4'h3;
  localparam logic [3:0] S_EX2DR = 4'h0;
  localparam logic [3:0] S_UPDDR = 4'h5;
  localparam logic [3:0] S_SELIR = 4'h4;
  localparam logic [3:0] S_CAPIR = 4'hE;
  localparam logic [3:0] S_SHIR  = 4'hA;
  localparam logic [3:0] S_EX1IR = 4'h9;
  localparam logic [3:0] S_PSIR  = 4'hB;
  localparam logic [3:0] S_EX2IR = 4'h8;
  localparam logic [3:0] S_UPDIR = 4'hD;

  logic [3:0]          state_q, state_d;
  logic [IR_WIDTH-1:0] sr_q, sr_d;
  logic [IR_WIDTH-1:0] inst_q, inst_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TLR:   state_d = EJ_TMS ? S_TLR   : S_RTI;
      S_RTI:   state_d = EJ_TMS ? S_SELDR : S_RTI;
      S_SELDR: state_d = EJ_TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: state_d = EJ_TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  state_d = EJ_TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: state_d = EJ_TMS ? S_UPDDR : S_PSDR;
      S_PSDR:  state_d = EJ_TMS ? S_EX2DR : S_PSDR;
      S_EX2DR: state_d = EJ_TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: state_d = EJ_TMS ? S_SELDR : S_RTI;
      S_SELIR: state_d = EJ_TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: state_d = EJ_TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  state_d = EJ_TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: state_d = EJ_TMS ? S_UPDIR : S_PSIR;
      S_PSIR:  state_d = EJ_TMS ? S_EX2IR : S_PSIR;
      S_EX2IR: state_d = EJ_TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: state_d = EJ_TMS ? S_SELDR : S_RTI;
      default: state_d = S_TLR;
    endcase
  end

  // TDI enters at the MSB so the instruction is scanned LSB-first
  always_comb begin
    sr_d = sr_q;
    if (state_q == S_CAPIR) begin
      sr_d = IR_CAPTURE;
    end else if (state_q == S_SHIR) begin
      sr_d = {EJ_TDI, sr_q[IR_WIDTH-1:1]};
    end
  end

  always_comb begin
    inst_d = inst_q;
    if (state_q == S_TLR) begin
      inst_d = IR_RESET;
    end else if (state_q == S_UPDIR) begin
      inst_d = sr_q;
    end
  end

  always_ff @(posedge EJ_TCK or posedge treset) begin
    if (treset) begin
      state_q <= S_TLR;
      sr_q    <= IR_CAPTURE;
      inst_q  <= IR_RESET;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      inst_q  <= inst_d;
    end
  end

  assign tap_state        = state_q;
  assign test_logic_reset = (state_q == S_TLR);
  assign capture_dr       = (state_q == S_CAPDR);
  assign shift_dr         = (state_q == S_SHDR);
  assign update_dr        = (state_q == S_UPDDR);
  assign capture_ir       = (state_q == S_CAPIR);
  assign shift_ir         = (state_q == S_SHIR);
  assign update_ir        = (state_q == S_UPDIR);
  assign ir_inst          = inst_q;
  assign ir_tdo           = sr_q[0];
  assign tdo_en           = shift_dr | shift_ir;

endmodule

// File: doc/m14k_ejt_tapfsm.md
Name: m14k_ejt_tapfsm

Overview:
- EJTAG TAP controller: the IEEE 1149.1 16-state TAP state machine plus the EJTAG instruction register.
- Sits directly upstream of the TAP gating cells (2-input AND gates).
- Produces the per-state enables (capture/shift/update for DR and IR) that those gates combine with TCK and instruction decodes.
- Also owns IR shifting, the IR TDO path and the current-instruction output consumed by DR select logic.

Parameters:
- IR_WIDTH, 5, instruction register length in bits (must be >= 2).
- IR_RESET, 5'h01, instruction loaded in Test-Logic-Reset (IDCODE).
- IR_CAPTURE, 5'h01, value parallel-loaded into the IR shift register in Capture-IR; bits[1:0] must be 2'b01.

Ports:
- EJ_TCK  input  1  TAP clock; all state updates on rising edge.
- treset  input  1  asynchronous, active-high reset; forces Test-Logic-Reset.
- EJ_TMS  input  1  test mode select, sampled on rising EJ_TCK.
- EJ_TDI  input  1  test data in, sampled on rising EJ_TCK in Shift-IR.
- tap_state  output  4  current state encoding (see Behaviour).
- test_logic_reset  output  1  state == TLR.
- capture_dr  output  1  state == Capture-DR.
- shift_dr  output  1  state == Shift-DR.
- update_dr  output  1  state == Update-DR.
- capture_ir  output  1  state == Capture-IR.
- shift_ir  output  1  state == Shift-IR.
- update_ir  output  1  state == Update-IR.
- ir_inst  output  IR_WIDTH  current instruction.
- ir_tdo  output  1  IR shift register bit 0.
- tdo_en  output  1  shift_dr | shift_ir.

Behaviour:
Clocking and reset:
- Single clock domain: EJ_TCK. Reset is asynchronous and active-high (treset).
- On treset: state = TLR (4'hF); IR shift reg = IR_CAPTURE; ir_inst = IR_RESET.
- Reset values of all 1-bit decode outputs: test_logic_reset=1, all others 0; tdo_en=0; ir_tdo = IR_CAPTURE[0]=1.
- treset asserted mid-operation (any state, including mid Shift-IR) aborts immediately. No partial IR update ever reaches ir_inst.

State encoding (4 bits, fixed, visible on tap_state):
- TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5.
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.

Transitions on rising EJ_TCK, given as (TMS=0 / TMS=1):
- TLR: RTI / TLR
- RTI: RTI / SelDR
- SelDR: CapDR / SelIR
- CapDR: ShDR / Ex1DR
- ShDR: ShDR / Ex1DR
- Ex1DR: PauseDR / UpdDR
- PauseDR: PauseDR / Ex2DR
- Ex2DR: ShDR / UpdDR
- UpdDR: RTI / SelDR
- SelIR: CapIR / TLR
- IR branch mirrors the DR branch (CapIR … UpdIR).
- Five consecutive TMS=1 clocks reach TLR from any state.

Decode outputs:
- All decode outputs are Moore: a combinational decode of the state register only.
- No combinational path from EJ_TMS or EJ_TDI to any output.

IR shift register (rising EJ_TCK):
- In CapIR: load IR_CAPTURE.
- In ShIR: shift right, with EJ_TDI entering the MSB.
- In all other states: hold.

ir_inst:
- Loads the IR shift register contents on the rising edge at which state == UpdIR.
- Forced to IR_RESET on any rising edge while state == TLR.
- Otherwise holds.
- Visible the cycle after the UpdIR edge.

Other rules:
- ir_tdo is always the shift register LSB. Downstream TDO mux/retiming is outside this block.
- Latency: EJ_TMS sampled at edge N is reflected in tap_state and the decodes after edge N.
- No illegal states: all 16 encodings are used. X on EJ_TMS need not be handled.

Test Plan:
1. Reset to RTI: pulse treset while EJ_TCK is idle → tap_state=F, test_logic_reset=1, ir_inst=5'h01. Then one clock with TMS=0 → tap_state=C, test_logic_reset=0.
2. Five TMS=1 escape: from ShDR, PauseIR and RTI (each case separately), apply 5 clocks of TMS=1 → TLR reached on or before the 5th edge. Also ir_inst=5'h01 after a prior load of 5'h0A.
3. IR scan: from RTI, TMS sequence 1,1,0,0 → CapIR.
   - Shift in 5'h0A LSB-first (last bit with TMS=1), then TMS=1 → UpdIR, then TMS=0.
   - Expect ir_tdo sequence 1,0,0,0,0 (the capture value).
   - Expect ir_inst=5'h0A after the UpdIR edge, and unchanged before it.
4. DR path: RTI → SelDR → CapDR → ShDR ×3 → Ex1DR → PauseDR ×2 → Ex2DR → ShDR → Ex1DR → UpdDR.
   - Expect capture_dr, shift_dr and update_dr each high exactly in their states.
   - Expect tdo_en high only in ShDR cycles (4 total).
   - Expect ir_inst unchanged throughout.
5. Reset mid IR scan: assert treset asynchronously after 2 Shift-IR bits of 5'h1F → immediate tap_state=F, ir_inst=5'h01, tdo_en=0, with no clock edge required.
6. Ex2IR re-entry: CapIR → ShIR ×2 → Ex1IR → PauseIR → Ex2IR → ShIR ×3 → Ex1IR → UpdIR, shifting in 5'h13 → ir_inst=5'h13.
